// File: rtl/uart_loader.sv
// Boot loader behind the uart_rx FIFO: parses A5-framed WRITE/JUMP packets into memory writes and jumps.
// Define UART_LOADER_CKSUM_EN to enforce the trailing checksum byte.
module uart_loader #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx_rdy,
  input  logic [7:0]        i_rx_data,
  output logic              o_rx_done,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_mem_we,
  input  logic              i_mem_ack,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_jump,
  output logic [ADDR_W-1:0] o_jump_addr
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, LEN, DATA, WRITE, CKSUM} state_t;

  state_t            state_q;
  logic [7:0]        byte_q;
  logic [23:0]       shift_q;
  logic [1:0]        idx_q;
  logic              isJump_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       count_q;
  logic [31:0]       idle_q;
  logic              rxDone_q, memWe_q, done_q, err_q, jump_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] jumpAddr_q;

  logic [31:0] word_d;
  logic [15:0] len_d;
  logic        timeoutHit, consume, cksumOk;

  // A byte is latched on the consume edge and acted on one cycle later, which also spaces the done pulses.
  assign word_d     = {byte_q, shift_q};
  assign len_d      = {byte_q, shift_q[23:16]};
  assign timeoutHit = (TIMEOUT_CYCLES != 0) && (state_q != IDLE) && (state_q != WRITE) &&
                      !rxDone_q && (idle_q >= 32'(TIMEOUT_CYCLES - 1));
  assign consume    = (state_q != WRITE) && !rxDone_q && i_rx_rdy && !timeoutHit;

`ifdef UART_LOADER_CKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sum_q <= 8'h00;
    end else if (rxDone_q) begin
      if (state_q == IDLE) sum_q <= 8'h00;
      else if (state_q != CKSUM) sum_q <= sum_q + byte_q;
    end
  end

  assign cksumOk = (byte_q == sum_q);
`else
  assign cksumOk = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      byte_q     <= 8'h00;
      shift_q    <= 24'h0;
      idx_q      <= 2'd0;
      isJump_q   <= 1'b0;
      addr_q     <= '0;
      count_q    <= 16'h0;
      idle_q     <= 32'h0;
      rxDone_q   <= 1'b0;
      memWe_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      jump_q     <= 1'b0;
      wdata_q    <= 32'h0;
      jumpAddr_q <= '0;
    end else begin
      rxDone_q <= 1'b0;
      done_q   <= 1'b0;
      jump_q   <= 1'b0;

      if (consume || (memWe_q && i_mem_ack) || state_q == IDLE || state_q == WRITE) idle_q <= 32'h0;
      else idle_q <= idle_q + 32'h1;

      if (consume) begin
        rxDone_q <= 1'b1;
        byte_q   <= i_rx_data;
      end

      if (timeoutHit) begin
        err_q   <= 1'b1;
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (rxDone_q && byte_q == 8'hA5) begin
            err_q   <= 1'b0;
            state_q <= CMD;
          end
          CMD: if (rxDone_q) begin
            if (byte_q == 8'h01 || byte_q == 8'h02) begin
              isJump_q <= (byte_q == 8'h02);
              idx_q    <= 2'd0;
              state_q  <= ADDR;
            end else begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end
          end
          ADDR: if (rxDone_q) begin
            shift_q <= word_d[31:8];
            idx_q   <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              if (word_d[1:0] != 2'b00) begin
                err_q   <= 1'b1;
                state_q <= IDLE;
              end else begin
                addr_q  <= word_d[ADDR_W-1:0];
                idx_q   <= 2'd0;
                state_q <= LEN;
              end
            end
          end
          LEN: if (rxDone_q) begin
            shift_q <= word_d[31:8];
            idx_q   <= idx_q + 2'd1;
            if (idx_q == 2'd1) begin
              idx_q <= 2'd0;
              if (isJump_q || len_d == 16'h0) begin
                count_q <= 16'h0;
                state_q <= CKSUM;
              end else begin
                count_q <= len_d;
                state_q <= DATA;
              end
            end
          end
          DATA: if (rxDone_q) begin
            shift_q <= word_d[31:8];
            idx_q   <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              wdata_q <= word_d;
              memWe_q <= 1'b1;
              state_q <= WRITE;
            end
          end
          WRITE: if (memWe_q && i_mem_ack) begin
            memWe_q <= 1'b0;
            addr_q  <= addr_q + ADDR_W'(4);
            count_q <= count_q - 16'h1;
            state_q <= (count_q == 16'h1) ? CKSUM : DATA;
          end
          CKSUM: if (rxDone_q) begin
            if (cksumOk) begin
              done_q <= 1'b1;
              if (isJump_q) begin
                jump_q     <= 1'b1;
                jumpAddr_q <= addr_q;
              end
            end else begin
              err_q <= 1'b1;
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_rx_done   = rxDone_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_we    = memWe_q;
  assign o_busy      = (state_q != IDLE);
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_jump      = jump_q;
  assign o_jump_addr = jumpAddr_q;

endmodule

// File: tb/tb_uart_loader.sv
// Testbench for uart_loader: byte FIFO model feeds packets, a write scoreboard and pulse counters check results.
module tb_uart_loader;
  localparam int TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxRdy;
  logic [7:0]  rxData;
  logic        rxDone;
  logic [31:0] memAddr, memWdata;
  logic        memWe, memAck;
  logic        busy, done, err, jump;
  logic [31:0] jumpAddr;

  always #5 clk = ~clk;

  uart_loader #(.ADDR_W(32), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_rdy(rxRdy), .i_rx_data(rxData), .o_rx_done(rxDone),
    .o_mem_addr(memAddr), .o_mem_wdata(memWdata), .o_mem_we(memWe), .i_mem_ack(memAck),
    .o_busy(busy), .o_done(done), .o_err(err), .o_jump(jump), .o_jump_addr(jumpAddr)
  );

  int total = 0;
  int bad = 0;
  logic [7:0]  rxQ[$];
  logic [31:0] expAddrQ[$], expDataQ[$];
  logic [31:0] wordQ[$];
  bit          ackAllowed = 1'b1;
  int          doneCount = 0, jumpCount = 0, writeCount = 0, rxDoneBackToBack = 0;
  logic [31:0] lastJumpAddr = 32'h0;
  logic        prevRxDone = 1'b0;
  logic [31:0] ea, ed;

  // FIFO model: pops the head after a consume pulse and presents the next byte.
  always @(negedge clk) begin
    if (rxDone && rxQ.size() > 0) void'(rxQ.pop_front());
    rxRdy  = (rxQ.size() > 0);
    rxData = (rxQ.size() > 0) ? rxQ[0] : 8'h00;
  end

  // Memory responder and scoreboard: every accepted write is compared against the expected queue.
  always @(negedge clk) begin
    if (rxDone && prevRxDone) rxDoneBackToBack++;
    prevRxDone = rxDone;
    if (done) doneCount++;
    if (jump) begin
      jumpCount++;
      lastJumpAddr = jumpAddr;
    end
    if (memAck) begin
      memAck = 1'b0;
    end else if (memWe && ackAllowed && !rst) begin
      writeCount++;
      total++;
      if (expAddrQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL write_unexpected got addr=%h data=%h expected no write", memAddr, memWdata);
      end else begin
        ea = expAddrQ.pop_front();
        ed = expDataQ.pop_front();
        if (memAddr !== ea || memWdata !== ed) begin
          bad++;
          $display("[TB] FAIL write_data got addr=%h data=%h expected addr=%h data=%h", memAddr, memWdata, ea, ed);
        end
      end
      memAck = 1'b1;
    end
  end

  task automatic sendPacket(input logic [7:0] cmd, input logic [31:0] addr, input logic [15:0] len, input bit corrupt);
    logic [7:0] sum;
    logic [7:0] b;
    logic [31:0] w;
    sum = 8'h00;
    rxQ.push_back(8'hA5);
    rxQ.push_back(cmd);
    sum += cmd;
    for (int i = 0; i < 4; i++) begin b = addr[8*i +: 8]; rxQ.push_back(b); sum += b; end
    for (int i = 0; i < 2; i++) begin b = len[8*i +: 8]; rxQ.push_back(b); sum += b; end
    for (int k = 0; k < wordQ.size(); k++) begin
      w = wordQ[k];
      for (int i = 0; i < 4; i++) begin b = w[8*i +: 8]; rxQ.push_back(b); sum += b; end
      if (cmd == 8'h01) begin
        expAddrQ.push_back(addr + 32'(4 * k));
        expDataQ.push_back(w);
      end
    end
    wordQ.delete();
    rxQ.push_back(corrupt ? sum + 8'h01 : sum);
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((rxQ.size() != 0 || busy || rxDone) && n < 3000);
    repeat (4) @(negedge clk);
    total++;
    if (n >= 3000) begin
      bad++;
      $display("[TB] FAIL %s_idle_wait got busy=%0b after %0d cycles expected idle", name, busy, n);
    end
  endtask

  task automatic waitBusy(input string name);
    int n;
    n = 0;
    while (!busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s_busy_wait got busy=%0b expected 1", name, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({rxDone, memWe, busy, done, err, jump} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags got %b expected 000000", {rxDone, memWe, busy, done, err, jump});
    end
    total++;
    if (memAddr !== 32'h0 || memWdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_mem got addr=%h data=%h expected 0/0", memAddr, memWdata);
    end
    total++;
    if (jumpAddr !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_jump_addr got %h expected 0", jumpAddr);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || rxDone !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release got busy=%0b rx_done=%0b expected 0/0", busy, rxDone);
    end
  endtask

  task automatic test_write;
    int d0, w0, j0;
    d0 = doneCount; w0 = writeCount; j0 = jumpCount;
    wordQ = '{32'h44332211, 32'h88776655};
    sendPacket(8'h01, 32'h100, 16'd2, 1'b0);
    waitIdle("write");
    total++;
    if (doneCount - d0 != 1) begin bad++; $display("[TB] FAIL write_done got %0d expected 1", doneCount - d0); end
    total++;
    if (writeCount - w0 != 2) begin bad++; $display("[TB] FAIL write_count got %0d expected 2", writeCount - w0); end
    total++;
    if (err !== 1'b0 || jumpCount != j0) begin bad++; $display("[TB] FAIL write_err got err=%0b jumps=%0d expected 0/0", err, jumpCount - j0); end
    total++;
    if (expAddrQ.size() != 0) begin bad++; $display("[TB] FAIL write_pending got %0d expected 0", expAddrQ.size()); end
  endtask

  task automatic test_jump;
    int d0, w0, j0;
    d0 = doneCount; w0 = writeCount; j0 = jumpCount;
    sendPacket(8'h02, 32'h0000_2000, 16'd0, 1'b0);
    waitIdle("jump");
    total++;
    if (jumpCount - j0 != 1 || lastJumpAddr !== 32'h2000) begin
      bad++;
      $display("[TB] FAIL jump_pulse got count=%0d addr=%h expected 1/00002000", jumpCount - j0, lastJumpAddr);
    end
    total++;
    if (jumpAddr !== 32'h2000) begin bad++; $display("[TB] FAIL jump_addr_held got %h expected 00002000", jumpAddr); end
    total++;
    if (writeCount != w0 || doneCount - d0 != 1 || err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL jump_side got writes=%0d done=%0d err=%0b expected 0/1/0", writeCount - w0, doneCount - d0, err);
    end
  endtask

  task automatic test_bad_cksum;
    int d0, w0;
    d0 = doneCount; w0 = writeCount;
    wordQ = '{32'hDEADBEEF};
    sendPacket(8'h01, 32'h200, 16'd1, 1'b1);
    waitIdle("bad_cksum");
    total++;
    if (writeCount - w0 != 1) begin bad++; $display("[TB] FAIL cksum_write got %0d expected 1", writeCount - w0); end
`ifdef UART_LOADER_CKSUM_EN
    total++;
    if (err !== 1'b1 || doneCount != d0) begin
      bad++;
      $display("[TB] FAIL cksum_bad got err=%0b done=%0d expected 1/0", err, doneCount - d0);
    end
`else
    total++;
    if (err !== 1'b0 || doneCount - d0 != 1) begin
      bad++;
      $display("[TB] FAIL cksum_ignored got err=%0b done=%0d expected 0/1", err, doneCount - d0);
    end
`endif
  endtask

  task automatic test_garbage;
    int d0;
    d0 = doneCount;
    rxQ.push_back(8'h00); rxQ.push_back(8'hFF); rxQ.push_back(8'h12);
    waitIdle("garbage");
    total++;
    if (busy !== 1'b0 || rxQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL garbage_discard got busy=%0b left=%0d expected 0/0", busy, rxQ.size());
    end
    rxQ.push_back(8'hA5);
    waitBusy("garbage");
    repeat (2) @(negedge clk);
    total++;
    if (err !== 1'b0) begin bad++; $display("[TB] FAIL sync_clears_err got %0b expected 0", err); end
    rxQ.push_back(8'h07);
    waitIdle("bad_cmd");
    total++;
    if (err !== 1'b1 || busy !== 1'b0 || doneCount != d0) begin
      bad++;
      $display("[TB] FAIL bad_cmd got err=%0b busy=%0b done=%0d expected 1/0/0", err, busy, doneCount - d0);
    end
  endtask

  task automatic test_stall;
    int d0, n;
    d0 = doneCount;
    ackAllowed = 1'b0;
    wordQ = '{32'hCAFEF00D};
    sendPacket(8'h01, 32'h300, 16'd1, 1'b0);
    n = 0;
    while (!memWe && n < 300) begin @(negedge clk); n++; end
    for (int c = 0; c < 150; c++) begin
      total++;
      if (memWe !== 1'b1 || memAddr !== 32'h300 || memWdata !== 32'hCAFEF00D || err !== 1'b0) begin
        bad++;
        $display("[TB] FAIL stall_hold cycle=%0d got we=%0b addr=%h data=%h err=%0b expected 1/00000300/cafef00d/0",
                 c, memWe, memAddr, memWdata, err);
      end
      @(negedge clk);
    end
    ackAllowed = 1'b1;
    waitIdle("stall");
    total++;
    if (err !== 1'b0 || doneCount - d0 != 1 || expAddrQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL stall_end got err=%0b done=%0d pending=%0d expected 0/1/0", err, doneCount - d0, expAddrQ.size());
    end
  endtask

  task automatic test_back_to_back;
    int d0, w0, j0;
    d0 = doneCount; w0 = writeCount; j0 = jumpCount;
    wordQ = '{32'h0000_0001, 32'h0000_0002};
    sendPacket(8'h01, 32'hFFFF_FFFC, 16'd2, 1'b0);
    wordQ = '{32'hA5A5_A5A5};
    sendPacket(8'h01, 32'h40, 16'd1, 1'b0);
    sendPacket(8'h01, 32'h80, 16'd0, 1'b0);
    sendPacket(8'h02, 32'h1234_5670, 16'd5, 1'b0);
    waitIdle("back_to_back");
    total++;
    if (doneCount - d0 != 4 || writeCount - w0 != 3) begin
      bad++;
      $display("[TB] FAIL b2b_counts got done=%0d writes=%0d expected 4/3", doneCount - d0, writeCount - w0);
    end
    total++;
    if (jumpCount - j0 != 1 || lastJumpAddr !== 32'h1234_5670 || err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_jump got count=%0d addr=%h err=%0b expected 1/12345670/0", jumpCount - j0, lastJumpAddr, err);
    end
  endtask

  task automatic test_misaligned;
    int d0;
    d0 = doneCount;
    sendPacket(8'h01, 32'h102, 16'd0, 1'b0);
    waitIdle("misaligned");
    total++;
    if (err !== 1'b1 || doneCount != d0) begin
      bad++;
      $display("[TB] FAIL misaligned got err=%0b done=%0d expected 1/0", err, doneCount - d0);
    end
  endtask

  task automatic test_timeout;
    int n;
    rxQ.push_back(8'hA5); rxQ.push_back(8'h01);
    rxQ.push_back(8'h00); rxQ.push_back(8'h01); rxQ.push_back(8'h00); rxQ.push_back(8'h00);
    n = 0;
    while ((rxQ.size() != 0 || rxDone) && n < 200) begin @(negedge clk); n++; end
    total++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL timeout_start got busy=%0b err=%0b expected 1/0", busy, err);
    end
    n = 0;
    while (!err && n < 400) begin @(negedge clk); n++; end
    total++;
    if (n < 95 || n > 105) begin
      bad++;
      $display("[TB] FAIL timeout_cycles got %0d expected about %0d", n, TIMEOUT);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL timeout_idle got busy=%0b expected 0", busy); end
  endtask

  task automatic test_reset_write;
    int n;
    ackAllowed = 1'b0;
    wordQ = '{32'h0BAD_F00D};
    sendPacket(8'h01, 32'h400, 16'd1, 1'b0);
    n = 0;
    while (!memWe && n < 300) begin @(negedge clk); n++; end
    total++;
    if (memWe !== 1'b1) begin bad++; $display("[TB] FAIL rst_write_setup got we=%0b expected 1", memWe); end
    rst = 1'b1;
    rxQ.delete();
    expAddrQ.delete();
    expDataQ.delete();
    @(negedge clk);
    total++;
    if ({memWe, busy, err, done, jump, rxDone} !== 6'b0 || memAddr !== 32'h0 || memWdata !== 32'h0 || jumpAddr !== 32'h0) begin
      bad++;
      $display("[TB] FAIL rst_write got flags=%b addr=%h data=%h jaddr=%h expected all 0",
               {memWe, busy, err, done, jump, rxDone}, memAddr, memWdata, jumpAddr);
    end
    @(negedge clk);
    rst = 1'b0;
    ackAllowed = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (memWe !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_write_after got we=%0b busy=%0b expected 0/0", memWe, busy);
    end
  endtask

  initial begin
    rst    = 1'b1;
    rxRdy  = 1'b0;
    rxData = 8'h00;
    memAck = 1'b0;
    test_reset;
    test_write;
    test_jump;
    test_bad_cksum;
    test_garbage;
    test_stall;
    test_back_to_back;
    test_misaligned;
    test_timeout;
    test_reset_write;
    total++;
    if (rxDoneBackToBack != 0) begin
      bad++;
      $display("[TB] FAIL rx_done_spacing got %0d back-to-back pulses expected 0", rxDoneBackToBack);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
